// File: rtl/mtm_alu_arbiter.sv
// rtl/mtm_alu_arbiter.sv - round-robin sharing of one ALU core between two request channels
// Optional WAIT-state timeout abort is enabled by defining MTM_ALU_ARB_TIMEOUT_EN.
module mtm_alu_arbiter #(
`ifdef MTM_ALU_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [7:0]  req0_CTL,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [7:0]  req1_CTL,
  output logic        alu_start,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [31:0] alu_C,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_C,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [7:0]  rsp_err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [7:0] TIMEOUT_CODE = 8'hE1;

  state_e      state_q;
  logic        pref_q;
  logic        alu_start_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [2:0]  alu_op_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_c_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic [7:0]  rsp_err_code_q;

  logic        grant0_d;
  logic        grant1_d;
  logic        accept_d;
  logic        sel_d;
  logic [31:0] sel_a_d;
  logic [31:0] sel_b_d;
  logic [7:0]  sel_ctl_d;

`ifdef MTM_ALU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_d;
  assign timeout_d = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // pref_q names the channel that wins when both are valid
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (rst_n && state_q == S_IDLE) begin
      if (req0_valid && (!req1_valid || !pref_q)) begin
        grant0_d = 1'b1;
      end else if (req1_valid) begin
        grant1_d = 1'b1;
      end
    end
  end

  assign accept_d  = grant0_d | grant1_d;
  assign sel_d     = grant1_d;
  assign sel_a_d   = grant1_d ? req1_A   : req0_A;
  assign sel_b_d   = grant1_d ? req1_B   : req0_B;
  assign sel_ctl_d = grant1_d ? req1_CTL : req0_CTL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pref_q         <= 1'b0;
      alu_start_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_c_q        <= '0;
      rsp_flags_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_err_code_q <= '0;
`ifdef MTM_ALU_ARB_TIMEOUT_EN
      wait_cnt_q     <= '0;
`endif
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            pref_q   <= ~sel_d;
            rsp_id_q <= sel_d;
            if (sel_ctl_d[7]) begin
              // error frames skip the ALU entirely
              rsp_valid_q    <= 1'b1;
              rsp_err_q      <= 1'b1;
              rsp_err_code_q <= sel_ctl_d;
              rsp_c_q        <= '0;
              rsp_flags_q    <= '0;
              state_q        <= S_RESP;
            end else begin
              alu_a_q     <= sel_a_d;
              alu_b_q     <= sel_b_d;
              alu_op_q    <= sel_ctl_d[6:4];
              alu_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
`ifdef MTM_ALU_ARB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            rsp_valid_q    <= 1'b1;
            rsp_err_q      <= 1'b0;
            rsp_err_code_q <= '0;
            rsp_c_q        <= alu_C;
            rsp_flags_q    <= alu_flags;
            state_q        <= S_RESP;
          end
`ifdef MTM_ALU_ARB_TIMEOUT_EN
          else if (timeout_d) begin
            rsp_valid_q    <= 1'b1;
            rsp_err_q      <= 1'b1;
            rsp_err_code_q <= TIMEOUT_CODE;
            rsp_c_q        <= '0;
            rsp_flags_q    <= '0;
            state_q        <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_c_q        <= '0;
            rsp_flags_q    <= '0;
            rsp_err_q      <= 1'b0;
            rsp_err_code_q <= '0;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready   = grant0_d;
  assign req1_ready   = grant1_d;
  assign alu_start    = alu_start_q;
  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_C        = rsp_c_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_err_code = rsp_err_code_q;

endmodule

// File: tb/tb_mtm_alu_arbiter.sv
// tb/tb_mtm_alu_arbiter.sv - randomized self-checking bench for mtm_alu_arbiter
// Exercises the MTM_ALU_ARB_TIMEOUT_EN build when that macro is defined.
module tb_mtm_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [7:0]  req0_CTL = '0, req1_CTL = '0;
  logic        alu_start;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_done = 1'b0;
  logic [31:0] alu_C = '0;
  logic [3:0]  alu_flags = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_C;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  rsp_err_code;

  int checks = 0;
  int errors = 0;
  bit last_id = 1'b1;  // reference model: channel served most recently

  mtm_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_CTL(req0_CTL),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_CTL(req1_CTL),
    .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_done(alu_done), .alu_C(alu_C), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_C(rsp_C),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_err_code(rsp_err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [46:0] rsp_vec();
    return {rsp_valid, rsp_id, rsp_err, rsp_err_code, rsp_flags, rsp_C};
  endfunction

  function automatic logic [120:0] all_outs();
    return {req0_ready, req1_ready, alu_start, alu_A, alu_B, alu_op, rsp_vec()};
  endfunction

  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) return ~last_id;
    return v1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; alu_done = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    last_id = 1'b1;
  endtask

  // one full transaction: arbitration, ALU phase (or error bypass), backpressure, handshake
  task automatic run_txn(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [7:0] c0,
                         input logic [7:0] c1, input int k, input int hold,
                         input logic [31:0] rc, input logic [3:0] rf, input string tag);
    bit w;
    logic [31:0] ea, eb;
    logic [7:0]  ec;
    logic [46:0] exp_rsp;
    w  = pick(v0, v1);
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    ec = w ? c1 : c0;
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_CTL = c0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_CTL = c1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== {~w, w}) begin
      errors++;
      $display("FAIL %s grant: got %b required %b", tag, {req0_ready, req1_ready}, {~w, w});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    last_id = w;
    if (ec[7]) begin
      exp_rsp = {1'b1, w, 1'b1, ec, 4'h0, 32'h0};
      checks++;
      if ({alu_start, rsp_vec()} !== {1'b0, exp_rsp}) begin
        errors++;
        $display("FAIL %s err_rsp: got %h required %h", tag, {alu_start, rsp_vec()}, {1'b0, exp_rsp});
      end
    end else begin
      checks++;
      if ({alu_start, alu_A, alu_B, alu_op, rsp_valid} !== {1'b1, ea, eb, ec[6:4], 1'b0}) begin
        errors++;
        $display("FAIL %s issue: got %h required %h", tag,
                 {alu_start, alu_A, alu_B, alu_op, rsp_valid}, {1'b1, ea, eb, ec[6:4], 1'b0});
      end
      tick();
      for (int i = 0; i < k; i++) begin
        checks++;
        if ({alu_start, alu_A, alu_B, alu_op, rsp_valid} !== {1'b0, ea, eb, ec[6:4], 1'b0}) begin
          errors++;
          $display("FAIL %s wait%0d: got %h required %h", tag, i,
                   {alu_start, alu_A, alu_B, alu_op, rsp_valid}, {1'b0, ea, eb, ec[6:4], 1'b0});
        end
        if (i == k - 1) begin
          alu_done = 1'b1; alu_C = rc; alu_flags = rf;
        end
        tick();
      end
      alu_done = 1'b0; alu_C = $urandom; alu_flags = 4'($urandom_range(0, 15));
      exp_rsp = {1'b1, w, 1'b0, 8'h00, rf, rc};
      checks++;
      if (rsp_vec() !== exp_rsp) begin
        errors++;
        $display("FAIL %s result: got %h required %h", tag, rsp_vec(), exp_rsp);
      end
    end
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1; req0_A = $urandom; req0_CTL = 8'($urandom);
      req1_valid = 1'b1; req1_A = $urandom; req1_CTL = 8'($urandom);
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp_vec()} !== {2'b00, exp_rsp}) begin
        errors++;
        $display("FAIL %s hold%0d: got %h required %h", tag, h,
                 {req0_ready, req1_ready, rsp_vec()}, {2'b00, exp_rsp});
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake rsp_valid: got %b required 0", tag, rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    rst_n = 1'b0;
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h required 0", all_outs());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    reset_dut();
    run_txn(1'b1, 1'b0, 32'd5, 32'd3, 32'd0, 32'd0, 8'h00, 8'h00, 2, 0, 32'd8, 4'h0, "basic");
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pick(1'b1, 1'b1) !== 1'(i % 2)) begin
        errors++;
        $display("FAIL rr_order%0d: got %b required %b", i, pick(1'b1, 1'b1), 1'(i % 2));
      end
      run_txn(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 8'h20, 8'h30, 1, 0,
              $urandom, 4'($urandom_range(0, 15)), "round_robin");
    end
  endtask

  task automatic test_error_frame();
    run_txn(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 8'h00, 8'hA5, 1, 0,
            32'h0, 4'h0, "error_frame");
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 1'b0, $urandom, $urandom, 32'h0, 32'h0, 8'h40, 8'h00, 3, 5,
            $urandom, 4'hA, "backpressure");
  endtask

  task automatic test_reset_in_wait();
    reset_dut();
    req0_valid = 1'b1; req0_A = 32'h1234; req0_B = 32'h5678; req0_CTL = 8'h10;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_in_wait outputs: got %h required 0", all_outs());
    end
    rst_n = 1'b1; alu_done = 1'b1; alu_C = 32'hDEAD; alu_flags = 4'hF;
    tick();
    alu_done = 1'b0;
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL late_done outputs: got %h required 0", all_outs());
    end
    last_id = 1'b1;
    run_txn(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 8'h50, 8'h60, 2, 1,
            $urandom, 4'h3, "after_reset");
  endtask

`ifdef MTM_ALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    reset_dut();
    for (int pass = 0; pass < 2; pass++) begin
      req0_valid = 1'b1; req0_A = $urandom; req0_B = $urandom; req0_CTL = 8'h10;
      tick();
      req0_valid = 1'b0;
      last_id = 1'b0;
      for (int i = 0; i < 16; i++) begin
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early%0d: got %b required 0", i, rsp_valid);
        end
      end
      if (pass == 1) begin
        alu_done = 1'b1; alu_C = 32'hCAFE0001; alu_flags = 4'h9;
      end
      tick();
      alu_done = 1'b0;
      checks++;
      if (pass == 0 && rsp_vec() !== {1'b1, 1'b0, 1'b1, 8'hE1, 4'h0, 32'h0}) begin
        errors++;
        $display("FAIL timeout_rsp: got %h required %h", rsp_vec(), {1'b1, 1'b0, 1'b1, 8'hE1, 4'h0, 32'h0});
      end else if (pass == 1 && rsp_vec() !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h9, 32'hCAFE0001}) begin
        errors++;
        $display("FAIL timeout_done_wins: got %h required %h", rsp_vec(), {1'b1, 1'b0, 1'b0, 8'h00, 4'h9, 32'hCAFE0001});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask
`else
  task automatic test_wait_hold();
    reset_dut();
    req0_valid = 1'b1; req0_A = $urandom; req0_B = $urandom; req0_CTL = 8'h10;
    tick();
    req0_valid = 1'b0;
    last_id = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d: got %b required 0", i, rsp_valid);
      end
    end
    alu_done = 1'b1; alu_C = 32'h0BADF00D; alu_flags = 4'h2;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_vec() !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h2, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL wait_hold_rsp: got %h required %h", rsp_vec(), {1'b1, 1'b0, 1'b0, 8'h00, 4'h2, 32'h0BADF00D});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit v0, v1;
    logic [7:0] c0, c1;
    for (int n = 0; n < 30; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      c0 = 8'($urandom); c0[7] = ($urandom_range(0, 3) == 0);
      c1 = 8'($urandom); c1[7] = ($urandom_range(0, 3) == 0);
      run_txn(v0, v1, $urandom, $urandom, $urandom, $urandom, c0, c1,
              $urandom_range(1, 4), $urandom_range(0, 3), $urandom,
              4'($urandom_range(0, 15)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_error_frame();
    test_backpressure();
    test_reset_in_wait();
`ifdef MTM_ALU_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_hold();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
